// File: rtl/lookahead_mport_ram_pkg.sv
// ---------------------------------------------------------------------------
// lookahead_mport_ram_pkg
//
// Shared declarations for the lookahead multiport RAM and its bank sub-module.
//   ram_state_t  : power-up sequencing states (RESET -> optional CLEAR -> READY)
//   calc_addr_w  : address width for a given depth, never narrower than 1 bit
// ---------------------------------------------------------------------------
package lookahead_mport_ram_pkg;

    // Power-up sequencing states. CLEAR is only visited when zero-fill is enabled.
    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_CLEAR = 2'd1,
        ST_READY = 2'd2
    } ram_state_t;

    // A single-word RAM still needs a 1-bit address port so the port lists
    // never collapse to zero width.
    function automatic int calc_addr_w(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/lookahead_ram_bank.sv
// ---------------------------------------------------------------------------
// lookahead_ram_bank
//
// One simple dual-port inferred RAM: a single byte-enabled write port and a
// single registered read port, both on clk. A read and a write to the same
// address on the same edge return the OLD word; the parent handles bypass.
// The read register only updates when rd_en is high, so the output holds.
//
// Ports
//   clk      in  : clock, rising edge
//   wr_en    in  : write strobe (caller guarantees wr_addr < DEPTH)
//   wr_addr  in  : write address
//   wr_data  in  : write data
//   wr_be    in  : per-byte write mask
//   rd_en    in  : read strobe (caller guarantees rd_addr < DEPTH)
//   rd_addr  in  : read address
//   rd_data  out : registered read data
// ---------------------------------------------------------------------------
module lookahead_ram_bank
    import lookahead_mport_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    localparam int ADDR_W    = calc_addr_w(DEPTH),
    localparam int BE_W      = DATA_WIDTH / 8
)(
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [BE_W-1:0]       wr_be,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Byte-lane write. Kept free of reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BE_W; b++) begin
                if (wr_be[b]) begin
                    mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    // Registered read. Non-blocking semantics give read-old-data on a
    // same-edge collision with the write above.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/lookahead_mport_ram.sv
// ---------------------------------------------------------------------------
// lookahead_mport_ram
//
// Write-first multiport RAM: one byte-enabled write port feeding NUM_RD
// replicated banks, each bank serving one read port with a one-cycle
// registered read. A read that collides with an accepted write on the same
// edge sees the new bytes through a per-port bypass register. Optionally
// zero-fills the whole array after reset before accepting writes.
//
// Ports
//   clk              in  : clock, rising edge
//   reset            in  : synchronous, active-high
//   wr_address       in  : write address (ADDR_W)
//   wr_writedata     in  : write data (DATA_WIDTH)
//   wr_byteenable    in  : per-byte write mask (BE_W)
//   wr_write         in  : write strobe
//   wr_waitrequest   out : high while writes are ignored (reset / clearing)
//   rd_address       in  : port p address at [p*ADDR_W +: ADDR_W]
//   rd_read          in  : per-port read strobe
//   rd_readdata      out : port p data at [p*DATA_WIDTH +: DATA_WIDTH]
//   rd_readdatavalid out : per-port data-valid, one cycle after rd_read
// ---------------------------------------------------------------------------
module lookahead_mport_ram
    import lookahead_mport_ram_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int DEPTH          = 4,
    parameter int NUM_RD         = 1,
    parameter int CLEAR_ON_RESET = 0,
    localparam int ADDR_W        = calc_addr_w(DEPTH),
    localparam int BE_W          = DATA_WIDTH / 8
)(
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDR_W-1:0]            wr_address,
    input  logic [DATA_WIDTH-1:0]        wr_writedata,
    input  logic [BE_W-1:0]              wr_byteenable,
    input  logic                         wr_write,
    output logic                         wr_waitrequest,
    input  logic [NUM_RD*ADDR_W-1:0]     rd_address,
    input  logic [NUM_RD-1:0]            rd_read,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_readdata,
    output logic [NUM_RD-1:0]            rd_readdatavalid
);

    // One extra bit so DEPTH itself is representable for range compares
    // (matters for non-power-of-2 depths where the address can overshoot).
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

    ram_state_t            state;
    logic [ADDR_W-1:0]     clr_cnt;

    logic                  clearing;
    logic                  wr_in_range;
    logic                  wr_accept;
    logic                  bank_wr_en;
    logic [ADDR_W-1:0]     bank_wr_addr;
    logic [DATA_WIDTH-1:0] bank_wr_data;
    logic [BE_W-1:0]       bank_wr_be;

    // Sequencing FSM. Leaving reset either starts a top-down zero-fill or
    // goes straight to READY. wr_waitrequest is registered alongside the
    // state so it is glitch-free and changes on the same edge as the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_RESET;
            clr_cnt        <= '0;
            wr_waitrequest <= 1'b1;
        end else begin
            case (state)
                ST_RESET: begin
                    if (CLEAR_ON_RESET != 0) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= ADDR_W'(DEPTH - 1);
                    end else begin
                        state          <= ST_READY;
                        wr_waitrequest <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt == '0) begin
                        state          <= ST_READY;
                        wr_waitrequest <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt - ADDR_W'(1);
                    end
                end
                ST_READY: begin
                    state <= ST_READY;
                end
                default: begin
                    state          <= ST_RESET;
                    wr_waitrequest <= 1'b1;
                end
            endcase
        end
    end

    // The shared write bus: the clear engine owns it during CLEAR, otherwise
    // only in-range user writes in READY get through. Out-of-range writes are
    // silently dropped.
    assign clearing     = (state == ST_CLEAR);
    assign wr_in_range  = ({1'b0, wr_address} < DEPTH_EXT);
    assign wr_accept    = (state == ST_READY) && wr_write && wr_in_range;
    assign bank_wr_en   = clearing || wr_accept;
    assign bank_wr_addr = clearing ? clr_cnt : wr_address;
    assign bank_wr_data = clearing ? '0 : wr_writedata;
    assign bank_wr_be   = clearing ? '1 : wr_byteenable;

    // One bank per read port, all receiving the identical write stream so the
    // copies never diverge.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        logic [ADDR_W-1:0]     rd_addr;
        logic                  rd_in_range;
        logic                  rd_accept;
        logic                  bank_rd_en;
        logic                  byp_hit;
        logic [DATA_WIDTH-1:0] bank_q;
        logic                  valid_q;
        logic                  zero_q;
        logic                  byp_q;
        logic [BE_W-1:0]       byp_be_q;
        logic [DATA_WIDTH-1:0] byp_data_q;
        logic [DATA_WIDTH-1:0] byp_mask;
        logic [DATA_WIDTH-1:0] merged;

        assign rd_addr     = rd_address[p*ADDR_W +: ADDR_W];
        assign rd_in_range = ({1'b0, rd_addr} < DEPTH_EXT);
        assign rd_accept   = rd_read[p] && (state != ST_RESET);
        assign bank_rd_en  = rd_accept && rd_in_range;
        assign byp_hit     = rd_accept && wr_accept && (rd_addr == wr_address);

        lookahead_ram_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_bank (
            .clk     (clk),
            .wr_en   (bank_wr_en),
            .wr_addr (bank_wr_addr),
            .wr_data (bank_wr_data),
            .wr_be   (bank_wr_be),
            .rd_en   (bank_rd_en),
            .rd_addr (rd_addr),
            .rd_data (bank_q)
        );

        // Per-port side registers captured with each accepted read: the
        // force-zero flag (clearing or out-of-range) and the bypass
        // flag/mask/data. They only move on an accepted read, which together
        // with the bank read register makes rd_readdata hold between reads.
        // zero_q resets high so the output reads 0 before the first read,
        // while the bank register itself is still unknown.
        always_ff @(posedge clk) begin
            if (reset) begin
                valid_q    <= 1'b0;
                zero_q     <= 1'b1;
                byp_q      <= 1'b0;
                byp_be_q   <= '0;
                byp_data_q <= '0;
            end else begin
                valid_q <= rd_accept;
                if (rd_accept) begin
                    zero_q     <= clearing || !rd_in_range;
                    byp_q      <= byp_hit;
                    byp_be_q   <= wr_byteenable;
                    byp_data_q <= wr_writedata;
                end
            end
        end

        // Expand the captured byte mask to bit lanes and overlay the bypassed
        // bytes on top of the old word coming out of the bank.
        always_comb begin
            byp_mask = '0;
            for (int b = 0; b < BE_W; b++) begin
                byp_mask[b*8 +: 8] = {8{byp_q & byp_be_q[b]}};
            end
            merged = zero_q ? '0 : ((bank_q & ~byp_mask) | (byp_data_q & byp_mask));
        end

        assign rd_readdata[p*DATA_WIDTH +: DATA_WIDTH] = merged;
        assign rd_readdatavalid[p]                     = valid_q;
    end

endmodule
